alu_branch_decoder: RTL and testbench
=====================================

ALU_BRANCH_DECODER -- requirements
Module: alu_branch_decoder

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  clock; ALU result register updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 word  input  16  instruction word.
REQ-005 status  input  8  CPU flags; bit0 Z, bit1 N, bit2 V, bit3 C (carry-in).
REQ-006 value1, value2  input  16 each  ALU operands.
REQ-007 operator_group  output  4  decoded group.
REQ-008 operator  output  4  decoded operation / condition code.
REQ-009 val  output  8  immediate.
REQ-010 flag_mask  output  8  flag set/clear mask.
REQ-011 rg1, rg2  output  3 each  register selects.
REQ-012 relative_addr  output  10  signed branch offset.
REQ-013 is_checked  output  1  branch condition true.
REQ-014 alu_out  output  16  registered ALU result.
REQ-015 alu_flags, alu_flags8  output  4 each  registered 16-bit / 8-bit result flags {C,V,N,Z} (bit3..bit0).

Function
REQ-016 Decode is combinational from word[15:12]: 000x RJMP=0; 0010 SFLAG=2; 0011 UFLAG=3; 0100 WRRMATH=4; 0101 WRSMATH=5; 0110 CRRMATH=6; 0111 CRSMATH=7; 1000 WRRMATH_MEM=8; 1001 WRSMATH_STACK=9; 1010 SPECIAL_LONG=10; 1011 SPECIAL=11; 11xx CRVMATH=12.
REQ-017 operator: RJMP {0,word[12:10]}; CRVMATH {0,word[13:11]}; otherwise word[11:8].
REQ-018 rg1: CRVMATH word[10:8], otherwise word[7:5]; rg2 = word[4:2] always.
REQ-019 val = flag_mask = word[7:0]; relative_addr = word[9:0], for all groups.
REQ-020 is_checked, combinational on operator and status: 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 !N; 7 V; 8-15 never (0).
REQ-021 ALU single mode active when operator_group is WRSMATH or CRSMATH; value2 ignored.
REQ-022 Two-operand ops: 0 ADD; 1 ADC (+status[3]); 2 SUB; 3 SBC (-status[3]); 4 AND; 5 OR; 6 XOR; 7 MOV (value2); 8-15 pass value1.
REQ-023 Single ops: 0 INC; 1 DEC; 2 NOT; 3 NEG; 4 SHL; 5 SHR logical; 6 ROL through carry (status[3] into bit0); 7 ROR through carry (status[3] into bit15); 8-15 pass value1.
REQ-024 Arithmetic modulo 2^16; C = carry out of bit15 for add/INC, borrow for SUB/SBC/DEC/NEG; V = signed overflow for add/sub forms, else 0.
REQ-025 Shifts/rotates: C = bit shifted out (value1[15] left, value1[0] right); logic/MOV/pass: C=0, V=0.
REQ-026 Z = (alu_out==0), N = alu_out[15].
REQ-027 alu_flags8 from same operation on bit7 view: Z8 = alu_out[7:0]==0, N8 = alu_out[7], C8 = carry/borrow out of bit7 (left shift/rotate: value1[7]; right: value1[0]), V8 = signed overflow at bit7 for add/sub forms, else 0.
REQ-028 alu_out, alu_flags, alu_flags8 capture on each rising clk edge; latency one clock from operand/word change. Decode and is_checked: zero latency.

Reset
REQ-029 reset asserted drives alu_out=0, alu_flags=0, alu_flags8=0 immediately, no clock; held while reset high; first capture on first rising edge after release.
REQ-030 Combinational outputs unaffected by reset.

Verification
REQ-031 word=16'h0C05, status=8'h08 -> group 0, operator 3, relative_addr 10'h005, is_checked 1; status=8'h00 -> is_checked 0.
REQ-032 word=16'h4000, value1=16'hFFFF, value2=16'h0001, one clk -> alu_out 16'h0000, alu_flags 4'b1001, alu_flags8 4'b1001.
REQ-033 word=16'hC9A5 -> group 12, operator 1, rg1 1, val 8'hA5.
REQ-034 word=16'h5520, value1=16'h0003, one clk -> group 5, operator 5, rg1 1, alu_out 16'h0001, alu_flags 4'b1000.
REQ-035 word=16'h4200 (SUB), value1=16'h0000, value2=16'h0001, one clk -> alu_out 16'hFFFF, alu_flags 4'b1010.
REQ-036 Nonzero result held, reset asserted between clock edges -> alu_out and both flag outputs 0 immediately.

Source files
------------

// File: rtl/alu_branch_decoder_if.sv
// Bundle of the instruction-decode and ALU signals of alu_branch_decoder.
//
//   word            instruction word (16)
//   status          CPU flags: bit0 Z, bit1 N, bit2 V, bit3 C (8)
//   value1, value2  ALU operands (16 each)
//   operator_group  decoded instruction group (4)
//   operator        decoded operation / condition code (4)
//   val, flag_mask  immediate byte and flag set/clear mask (8 each)
//   rg1, rg2        register selects (3 each)
//   relative_addr   signed branch offset (10)
//   is_checked      branch condition true (1)
//   alu_out         registered ALU result (16)
//   alu_flags       registered 16-bit result flags {C,V,N,Z} (4)
//   alu_flags8      registered 8-bit result flags {C,V,N,Z} (4)
//
// master: the CPU side that supplies the instruction and operands.
// slave : the decoder/ALU.
interface alu_branch_decoder_if;
  logic [15:0] word;
  logic [7:0]  status;
  logic [15:0] value1;
  logic [15:0] value2;
  logic [3:0]  operator_group;
  logic [3:0]  operator;
  logic [7:0]  val;
  logic [7:0]  flag_mask;
  logic [2:0]  rg1;
  logic [2:0]  rg2;
  logic [9:0]  relative_addr;
  logic        is_checked;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  alu_flags8;

  modport master (
    output word, status, value1, value2,
    input  operator_group, operator, val, flag_mask, rg1, rg2,
           relative_addr, is_checked, alu_out, alu_flags, alu_flags8
  );

  modport slave (
    input  word, status, value1, value2,
    output operator_group, operator, val, flag_mask, rg1, rg2,
           relative_addr, is_checked, alu_out, alu_flags, alu_flags8
  );
endinterface

// File: rtl/alu_branch_decoder.sv
// Instruction decoder, branch-condition evaluator and registered ALU.
//
//   clk    rising-edge clock for the ALU result registers
//   reset  asynchronous, active-high; clears alu_out/alu_flags/alu_flags8
//   bus    alu_branch_decoder_if.slave (see interface file for fields)
//
// Decode fields and is_checked are purely combinational (zero latency).
// The ALU result and both flag sets are captured one clock after the
// word/operands are presented.
module alu_branch_decoder (
  input  logic                 clk,
  input  logic                 reset,
  alu_branch_decoder_if.slave  bus
);

  typedef enum logic [3:0] {
    G_RJMP          = 4'd0,
    G_SFLAG         = 4'd2,
    G_UFLAG         = 4'd3,
    G_WRRMATH       = 4'd4,
    G_WRSMATH       = 4'd5,
    G_CRRMATH       = 4'd6,
    G_CRSMATH       = 4'd7,
    G_WRRMATH_MEM   = 4'd8,
    G_WRSMATH_STACK = 4'd9,
    G_SPECIAL_LONG  = 4'd10,
    G_SPECIAL       = 4'd11,
    G_CRVMATH       = 4'd12
  } group_e;

  group_e      grp;
  logic [3:0]  op;
  logic        cin;

  assign cin = bus.status[3];

  // ---------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grp = G_RJMP;
    casez (bus.word[15:12])
      4'b000?: grp = G_RJMP;
      4'b0010: grp = G_SFLAG;
      4'b0011: grp = G_UFLAG;
      4'b0100: grp = G_WRRMATH;
      4'b0101: grp = G_WRSMATH;
      4'b0110: grp = G_CRRMATH;
      4'b0111: grp = G_CRSMATH;
      4'b1000: grp = G_WRRMATH_MEM;
      4'b1001: grp = G_WRSMATH_STACK;
      4'b1010: grp = G_SPECIAL_LONG;
      4'b1011: grp = G_SPECIAL;
      4'b11??: grp = G_CRVMATH;
      default: grp = G_RJMP;
    endcase
  end

  // RJMP and CRVMATH borrow high word bits for the opcode, so their
  // operator and rg1 fields sit at different positions.
  always_comb begin
    op      = bus.word[11:8];
    bus.rg1 = bus.word[7:5];
    if (grp == G_RJMP) begin
      op = {1'b0, bus.word[12:10]};
    end else if (grp == G_CRVMATH) begin
      op      = {1'b0, bus.word[13:11]};
      bus.rg1 = bus.word[10:8];
    end
  end

  assign bus.operator_group = grp;
  assign bus.operator       = op;
  assign bus.rg2            = bus.word[4:2];
  assign bus.val            = bus.word[7:0];
  assign bus.flag_mask      = bus.word[7:0];
  assign bus.relative_addr  = bus.word[9:0];

  // Branch condition: status bit0 Z, bit1 N, bit2 V, bit3 C.
  always_comb begin
    bus.is_checked = 1'b0;
    case (op)
      4'd1:    bus.is_checked =  bus.status[0];
      4'd2:    bus.is_checked = ~bus.status[0];
      4'd3:    bus.is_checked =  bus.status[3];
      4'd4:    bus.is_checked = ~bus.status[3];
      4'd5:    bus.is_checked =  bus.status[1];
      4'd6:    bus.is_checked = ~bus.status[1];
      4'd7:    bus.is_checked =  bus.status[2];
      default: bus.is_checked = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------
  // All add/subtract forms share one adder: subtraction is
  // opa + ~opb + ~borrow_in, so the adder carry-out is the inverted borrow.
  logic        single;
  logic        arith;
  logic        is_sub;
  logic        k;
  logic [15:0] opa, opb, b_eff;
  logic        c_in;
  logic [16:0] sum;
  logic [8:0]  sum8;
  logic [15:0] res;
  logic        c, v, c8, v8;

  assign single = (grp == G_WRSMATH) || (grp == G_CRSMATH);

  always_comb begin
    arith  = 1'b0;
    is_sub = 1'b0;
    k      = 1'b0;
    opa    = bus.value1;
    opb    = bus.value2;
    res    = bus.value1;
    c      = 1'b0;
    v      = 1'b0;
    c8     = 1'b0;
    v8     = 1'b0;

    if (!single) begin
      case (op)
        4'd0: arith = 1'b1;
        4'd1: begin arith = 1'b1; k = cin; end
        4'd2: begin arith = 1'b1; is_sub = 1'b1; end
        4'd3: begin arith = 1'b1; is_sub = 1'b1; k = cin; end
        4'd4: res = bus.value1 & bus.value2;
        4'd5: res = bus.value1 | bus.value2;
        4'd6: res = bus.value1 ^ bus.value2;
        4'd7: res = bus.value2;
        default: res = bus.value1;
      endcase
    end else begin
      case (op)
        4'd0: begin arith = 1'b1; opb = 16'd1; end
        4'd1: begin arith = 1'b1; opb = 16'd1; is_sub = 1'b1; end
        4'd2: res = ~bus.value1;
        4'd3: begin arith = 1'b1; opa = 16'd0; opb = bus.value1; is_sub = 1'b1; end
        4'd4: begin
          res = {bus.value1[14:0], 1'b0};
          c   = bus.value1[15];
          c8  = bus.value1[7];
        end
        4'd5: begin
          res = {1'b0, bus.value1[15:1]};
          c   = bus.value1[0];
          c8  = bus.value1[0];
        end
        4'd6: begin
          res = {bus.value1[14:0], cin};
          c   = bus.value1[15];
          c8  = bus.value1[7];
        end
        4'd7: begin
          res = {cin, bus.value1[15:1]};
          c   = bus.value1[0];
          c8  = bus.value1[0];
        end
        default: res = bus.value1;
      endcase
    end

    b_eff = is_sub ? ~opb : opb;
    c_in  = is_sub ? ~k : k;
    sum   = {1'b0, opa} + {1'b0, b_eff} + {16'd0, c_in};
    sum8  = {1'b0, opa[7:0]} + {1'b0, b_eff[7:0]} + {8'd0, c_in};

    if (arith) begin
      res = sum[15:0];
      c   = sum[16] ^ is_sub;
      c8  = sum8[8] ^ is_sub;
      v   = (opa[15] == b_eff[15]) && (sum[15] != opa[15]);
      v8  = (opa[7] == b_eff[7]) && (sum8[7] != opa[7]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    if (reset) begin
      bus.alu_out    <= 16'd0;
      bus.alu_flags  <= 4'd0;
      bus.alu_flags8 <= 4'd0;
    end else begin
      bus.alu_out    <= res;
      bus.alu_flags  <= {c, v, res[15], res == 16'd0};
      bus.alu_flags8 <= {c8, v8, res[7], res[7:0] == 8'd0};
    end
  end

endmodule

// File: tb/tb_alu_branch_decoder.sv
// Self-checking bench for alu_branch_decoder: directed vectors plus
// randomized instructions compared against an integer-arithmetic model.
module tb_alu_branch_decoder;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_branch_decoder_if bus ();

  alu_branch_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_group(input logic [15:0] w);
    int top = int'(w) / 4096;
    if (top < 2)  return 0;
    if (top < 12) return top;
    return 12;
  endfunction

  function automatic int m_op(input logic [15:0] w);
    int g = m_group(w);
    if (g == 0)  return (int'(w) / 1024) % 8;
    if (g == 12) return (int'(w) / 2048) % 8;
    return (int'(w) / 256) % 16;
  endfunction

  function automatic int m_rg1(input logic [15:0] w);
    if (m_group(w) == 12) return (int'(w) / 256) % 8;
    return (int'(w) / 32) % 8;
  endfunction

  function automatic int m_cond(input logic [15:0] w, input logic [7:0] s);
    int z = int'(s[0]);
    int n = int'(s[1]);
    int vv = int'(s[2]);
    int cc = int'(s[3]);
    case (m_op(w))
      1: return z;
      2: return 1 - z;
      3: return cc;
      4: return 1 - cc;
      5: return n;
      6: return 1 - n;
      7: return vv;
      default: return 0;
    endcase
  endfunction

  // Exact integer add/subtract at a given width: carry/borrow from the
  // unsigned result range, overflow from the signed result range.
  function automatic void arith(input int x, input int y, input int k, input int sub,
                                input int width, output int r, output bit c, output bit v);
    int m  = 1 << width;
    int ux = x % m;
    int uy = y % m;
    int full, sx, sy, sf;
    full = (sub != 0) ? ux - uy - k : ux + uy + k;
    c    = (sub != 0) ? (full < 0) : (full >= m);
    r    = (full + m) % m;
    sx   = (ux >= m / 2) ? ux - m : ux;
    sy   = (uy >= m / 2) ? uy - m : uy;
    sf   = (sub != 0) ? sx - sy - k : sx + sy + k;
    v    = (sf >= m / 2) || (sf < -(m / 2));
  endfunction

  function automatic void m_alu(input logic [15:0] w, input logic [7:0] s,
                                input logic [15:0] v1, input logic [15:0] v2,
                                output logic [15:0] ro, output logic [3:0] f,
                                output logic [3:0] f8);
    int a = int'(v1);
    int b = int'(v2);
    int ci = int'(s[3]);
    int g = m_group(w);
    int op = m_op(w);
    int r, r8, x, y, k, sub;
    bit c, v, c8, v8, is_ar;
    r = a; c = 0; v = 0; c8 = 0; v8 = 0; is_ar = 0;
    x = a; y = b; k = 0; sub = 0;
    if (!(g == 5 || g == 7)) begin
      case (op)
        0: is_ar = 1;
        1: begin is_ar = 1; k = ci; end
        2: begin is_ar = 1; sub = 1; end
        3: begin is_ar = 1; sub = 1; k = ci; end
        4: r = a & b;
        5: r = a | b;
        6: r = a ^ b;
        7: r = b;
        default: r = a;
      endcase
    end else begin
      case (op)
        0: begin is_ar = 1; y = 1; end
        1: begin is_ar = 1; y = 1; sub = 1; end
        2: r = 65535 - a;
        3: begin is_ar = 1; x = 0; y = a; sub = 1; end
        4: begin r = (a * 2) % 65536; c = (a >= 32768); c8 = ((a / 128) % 2) == 1; end
        5: begin r = a / 2; c = (a % 2) == 1; c8 = c; end
        6: begin r = (a * 2) % 65536 + ci; c = (a >= 32768); c8 = ((a / 128) % 2) == 1; end
        7: begin r = a / 2 + ci * 32768; c = (a % 2) == 1; c8 = c; end
        default: r = a;
      endcase
    end
    if (is_ar) begin
      arith(x, y, k, sub, 16, r, c, v);
      arith(x, y, k, sub, 8, r8, c8, v8);
    end
    ro = 16'(r);
    f  = {c, v, r >= 32768, r == 0};
    f8 = {c8, v8, ((r / 128) % 2) == 1, (r % 256) == 0};
  endfunction

  // Present one instruction on the falling edge, check decode at once and
  // the ALU outputs just after the following rising edge.
  task automatic apply(input logic [15:0] w, input logic [7:0] s,
                       input logic [15:0] a, input logic [15:0] b);
    logic [15:0] er;
    logic [3:0]  ef, ef8;
    @(negedge clk);
    bus.word = w; bus.status = s; bus.value1 = a; bus.value2 = b;
    #1;
    check("group",    32'(bus.operator_group), 32'(m_group(w)));
    check("operator", 32'(bus.operator),       32'(m_op(w)));
    check("rg1",      32'(bus.rg1),            32'(m_rg1(w)));
    check("rg2",      32'(bus.rg2),            32'((int'(w) / 4) % 8));
    check("val",      32'(bus.val),            32'(int'(w) % 256));
    check("flag_mask", 32'(bus.flag_mask),     32'(int'(w) % 256));
    check("rel_addr", 32'(bus.relative_addr),  32'(int'(w) % 1024));
    check("is_checked", 32'(bus.is_checked),   32'(m_cond(w, s)));
    m_alu(w, s, a, b, er, ef, ef8);
    @(posedge clk);
    #1;
    check("alu_out",    32'(bus.alu_out),    32'(er));
    check("alu_flags",  32'(bus.alu_flags),  32'(ef));
    check("alu_flags8", 32'(bus.alu_flags8), 32'(ef8));
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h007F;
      5: return 16'h0080;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] w;

    // Reset active from time zero: registered outputs cleared with no edge.
    reset = 1'b1;
    bus.word = 16'h0C05; bus.status = 8'h08;
    bus.value1 = 16'hFFFF; bus.value2 = 16'h0001;
    #2;
    check("reset_out_noclk", 32'(bus.alu_out), 32'h0);
    check("reset_flags_noclk", 32'(bus.alu_flags), 32'h0);
    check("reset_flags8_noclk", 32'(bus.alu_flags8), 32'h0);
    // Decode is unaffected by reset.
    check("reset_decode_group", 32'(bus.operator_group), 32'd0);
    check("reset_decode_cond", 32'(bus.is_checked), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_out", 32'(bus.alu_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors.
    apply(16'h0C05, 8'h08, 16'h0000, 16'h0000);
    check("d031_group", 32'(bus.operator_group), 32'd0);
    check("d031_op", 32'(bus.operator), 32'd3);
    check("d031_rel", 32'(bus.relative_addr), 32'h005);
    check("d031_cond1", 32'(bus.is_checked), 32'd1);
    apply(16'h0C05, 8'h00, 16'h0000, 16'h0000);
    check("d031_cond0", 32'(bus.is_checked), 32'd0);

    apply(16'h4000, 8'h00, 16'hFFFF, 16'h0001);
    check("d032_out", 32'(bus.alu_out), 32'h0000);
    check("d032_flags", 32'(bus.alu_flags), 32'b1001);
    check("d032_flags8", 32'(bus.alu_flags8), 32'b1001);

    apply(16'hC9A5, 8'h00, 16'h1234, 16'h4321);
    check("d033_group", 32'(bus.operator_group), 32'd12);
    check("d033_op", 32'(bus.operator), 32'd1);
    check("d033_rg1", 32'(bus.rg1), 32'd1);
    check("d033_val", 32'(bus.val), 32'hA5);

    apply(16'h5520, 8'h00, 16'h0003, 16'hAAAA);
    check("d034_group", 32'(bus.operator_group), 32'd5);
    check("d034_op", 32'(bus.operator), 32'd5);
    check("d034_rg1", 32'(bus.rg1), 32'd1);
    check("d034_out", 32'(bus.alu_out), 32'h0001);
    check("d034_flags", 32'(bus.alu_flags), 32'b1000);

    apply(16'h4200, 8'h00, 16'h0000, 16'h0001);
    check("d035_out", 32'(bus.alu_out), 32'hFFFF);
    check("d035_flags", 32'(bus.alu_flags), 32'b1010);

    // Randomized instructions, biased towards the ALU groups.
    for (int i = 0; i < 400; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w[15:12] = 4'($urandom_range(4, 7));
      apply(w, 8'($urandom), pick_operand(), pick_operand());
    end

    // Asynchronous reset between edges clears a held nonzero result.
    apply(16'h4000, 8'h00, 16'h0005, 16'h0006);
    check("pre_reset_out", 32'(bus.alu_out), 32'd11);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_out", 32'(bus.alu_out), 32'h0);
    check("async_reset_flags", 32'(bus.alu_flags), 32'h0);
    check("async_reset_flags8", 32'(bus.alu_flags8), 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold_out", 32'(bus.alu_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_out", 32'(bus.alu_out), 32'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
